// File: rtl/bridge_rr_otc_arbiter.sv
// bridge_rr_otc_arbiter
//   Round-robin arbiter that funnels N_MASTER request channels onto a single
//   bridge/memory port. Each master's in-flight transactions are counted.
//   A master whose count has reached MAX_OUTSTANDING is stalled until one of
//   its responses comes back. Responses are routed back to the masters by
//   their one-hot ID.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   data_req_i ..       per-master request channel (flattened, master i in
//   data_aux_i          slice i)
//   data_gnt_o          per-master grant (the winner sees data_gnt_i)
//   data_req_o ..       request muxed from the winner, with the winner's
//   data_aux_o,         one-hot ID on data_ID_o
//   data_ID_o
//   data_gnt_i          bridge-port grant
//   data_r_valid_i,     response valid and its one-hot ID
//   data_r_ID_i
//   data_r_valid_o      response valid routed to the masters
//   stall_o             master has MAX_OUTSTANDING transactions in flight
//   err_o               sticky error: a response with no outstanding
//                       transaction, or a response ID that is not one-hot
module bridge_rr_otc_arbiter #(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int AUX_WIDTH       = 32,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTER-1:0]              data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]   data_add_i,
  input  logic [N_MASTER-1:0]              data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]     data_be_i,
  input  logic [N_MASTER*AUX_WIDTH-1:0]    data_aux_i,
  output logic [N_MASTER-1:0]              data_gnt_o,
  output logic                             data_req_o,
  output logic [ADDR_WIDTH-1:0]            data_add_o,
  output logic                             data_wen_o,
  output logic [DATA_WIDTH-1:0]            data_wdata_o,
  output logic [BE_WIDTH-1:0]              data_be_o,
  output logic [AUX_WIDTH-1:0]             data_aux_o,
  output logic [ID_WIDTH-1:0]              data_ID_o,
  input  logic                             data_gnt_i,
  input  logic                             data_r_valid_i,
  input  logic [ID_WIDTH-1:0]              data_r_ID_i,
  output logic [N_MASTER-1:0]              data_r_valid_o,
  output logic [N_MASTER-1:0]              stall_o,
  output logic                             err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(N_MASTER);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST    = PW'(N_MASTER - 1);

  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q [N_MASTER];
  logic [CW-1:0]       cnt_d [N_MASTER];
  logic                err_q, err_d;

  logic [N_MASTER-1:0] eligible;
  logic [N_MASTER-1:0] inc;
  logic [N_MASTER-1:0] dec;
  logic [PW-1:0]       win;
  logic                any_elig;
  logic [PW:0]         idx;
  logic                hs;
  logic                rsp_onehot;

  always_comb begin
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      eligible[i] = data_req_i[i] && (cnt_q[i] < CNT_MAX);
      stall_o[i]  = (cnt_q[i] == CNT_MAX);
    end
  end

  // Search starts at ptr and wraps at N_MASTER using a subtraction, so any
  // master count (not only powers of two) is handled.
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_MASTER)) begin
        idx = idx - (PW+1)'(N_MASTER);
      end
      if (!any_elig && eligible[idx[PW-1:0]]) begin
        any_elig = 1'b1;
        win      = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    data_req_o   = any_elig;
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    data_aux_o   = '0;
    data_ID_o    = '0;
    data_gnt_o   = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (any_elig && (win == PW'(i))) begin
        data_add_o    = data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_wen_o    = data_wen_i[i];
        data_wdata_o  = data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        data_be_o     = data_be_i[i*BE_WIDTH +: BE_WIDTH];
        data_aux_o    = data_aux_i[i*AUX_WIDTH +: AUX_WIDTH];
        data_ID_o[i]  = 1'b1;
        data_gnt_o[i] = data_gnt_i;
      end
    end
  end

  assign data_r_valid_o = data_r_valid_i ? N_MASTER'(data_r_ID_i) : '0;
  assign rsp_onehot     = $onehot(data_r_ID_i);
  assign hs             = any_elig & data_gnt_i;

  always_comb begin
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      inc[i] = hs && (win == PW'(i));
      dec[i] = data_r_valid_i && rsp_onehot && data_r_ID_i[i];
    end
  end

  // A grant and a response for the same master in one cycle cancel out.
  always_comb begin
    ptr_d = ptr_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (hs) begin
      ptr_d = (win == LAST) ? '0 : win + 1'b1;
    end
    if (data_r_valid_i && !rsp_onehot) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_bridge_rr_otc_arbiter.sv
// Bench for bridge_rr_otc_arbiter: instance A (4 masters, limit 2) and
// instance B (3 masters, limit 3) are compared every cycle against a
// behavioural model of the arbitration and accounting rules.
module tb_bridge_rr_otc_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0 = A, 1 = B; B uses the low 3 bits)
  logic [3:0]  req_i [2];
  logic        gnt_i [2];
  logic        rv_i  [2];
  logic [3:0]  rid_i [2];
  // Payload shared by both instances (16-bit addr/data, 2-bit be, 8-bit aux)
  logic [63:0] add_i, wdata_i;
  logic [3:0]  wen_i;
  logic [7:0]  be_i;
  logic [31:0] aux_i;

  logic [3:0]  gnt_o [2], id_o [2], rvo [2], stall [2];
  logic        req_o [2], wen_o [2], err_o [2];
  logic [15:0] add_o [2], wdata_o [2];
  logic [1:0]  be_o  [2];
  logic [7:0]  aux_o [2];
  logic [2:0]  gnt_b, id_b, rvo_b, stall_b;

  assign gnt_o[1] = {1'b0, gnt_b};
  assign id_o[1]  = {1'b0, id_b};
  assign rvo[1]   = {1'b0, rvo_b};
  assign stall[1] = {1'b0, stall_b};

  bridge_rr_otc_arbiter #(
    .N_MASTER(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .AUX_WIDTH(8),
    .ID_WIDTH(4), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .data_req_i(req_i[0]), .data_add_i(add_i), .data_wen_i(wen_i),
    .data_wdata_i(wdata_i), .data_be_i(be_i), .data_aux_i(aux_i),
    .data_gnt_o(gnt_o[0]), .data_req_o(req_o[0]), .data_add_o(add_o[0]),
    .data_wen_o(wen_o[0]), .data_wdata_o(wdata_o[0]), .data_be_o(be_o[0]),
    .data_aux_o(aux_o[0]), .data_ID_o(id_o[0]), .data_gnt_i(gnt_i[0]),
    .data_r_valid_i(rv_i[0]), .data_r_ID_i(rid_i[0]),
    .data_r_valid_o(rvo[0]), .stall_o(stall[0]), .err_o(err_o[0])
  );

  bridge_rr_otc_arbiter #(
    .N_MASTER(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .AUX_WIDTH(8),
    .ID_WIDTH(3), .MAX_OUTSTANDING(3)
  ) dut_b (
    .clk(clk), .rst(rst),
    .data_req_i(req_i[1][2:0]), .data_add_i(add_i[47:0]),
    .data_wen_i(wen_i[2:0]), .data_wdata_i(wdata_i[47:0]),
    .data_be_i(be_i[5:0]), .data_aux_i(aux_i[23:0]),
    .data_gnt_o(gnt_b), .data_req_o(req_o[1]), .data_add_o(add_o[1]),
    .data_wen_o(wen_o[1]), .data_wdata_o(wdata_o[1]), .data_be_o(be_o[1]),
    .data_aux_o(aux_o[1]), .data_ID_o(id_b), .data_gnt_i(gnt_i[1]),
    .data_r_valid_i(rv_i[1]), .data_r_ID_i(rid_i[1][2:0]),
    .data_r_valid_o(rvo_b), .stall_o(stall_b), .err_o(err_o[1])
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_ptr [2];
  int m_cnt [2][4];
  bit m_err [2];

  logic [3:0] rot_a [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] rot_b [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

  function automatic int nm(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int mx(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int winner(input int k, input logic [3:0] req);
    for (int o = 0; o < nm(k); o++) begin
      int m;
      m = (m_ptr[k] + o) % nm(k);
      if (req[m] && m_cnt[k][m] < mx(k)) return m;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      m_err[k] = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    end
  endtask

  task automatic model_check(input int k);
    int w;
    string p;
    logic [3:0] e_id, e_gnt, e_stall;
    p = (k == 0) ? "A" : "B";
    w = winner(k, req_i[k]);
    e_id = '0;
    e_gnt = '0;
    e_stall = '0;
    if (w >= 0) begin
      e_id[w] = 1'b1;
      e_gnt[w] = gnt_i[k];
    end
    for (int i = 0; i < nm(k); i++) e_stall[i] = (m_cnt[k][i] == mx(k));
    chk({p, ".req_o"}, 64'(req_o[k]), 64'(w >= 0));
    chk({p, ".id_o"}, 64'(id_o[k]), 64'(e_id));
    chk({p, ".gnt_o"}, 64'(gnt_o[k]), 64'(e_gnt));
    chk({p, ".add_o"}, 64'(add_o[k]), (w >= 0) ? 64'(add_i[w*16 +: 16]) : 64'd0);
    chk({p, ".wen_o"}, 64'(wen_o[k]), (w >= 0) ? 64'(wen_i[w]) : 64'd0);
    chk({p, ".wdata_o"}, 64'(wdata_o[k]), (w >= 0) ? 64'(wdata_i[w*16 +: 16]) : 64'd0);
    chk({p, ".be_o"}, 64'(be_o[k]), (w >= 0) ? 64'(be_i[w*2 +: 2]) : 64'd0);
    chk({p, ".aux_o"}, 64'(aux_o[k]), (w >= 0) ? 64'(aux_i[w*8 +: 8]) : 64'd0);
    chk({p, ".r_valid_o"}, 64'(rvo[k]), rv_i[k] ? 64'(rid_i[k]) : 64'd0);
    chk({p, ".stall_o"}, 64'(stall[k]), 64'(e_stall));
    chk({p, ".err_o"}, 64'(err_o[k]), 64'(m_err[k]));
  endtask

  task automatic model_update(input int k);
    int w, j;
    bit hs;
    w = winner(k, req_i[k]);
    hs = (w >= 0) && gnt_i[k];
    j = -1;
    if (rv_i[k]) begin
      if ($countones(rid_i[k]) != 1) m_err[k] = 1'b1;
      else for (int i = 0; i < 4; i++) if (rid_i[k][i]) j = i;
    end
    if (hs) begin
      if (j != w) m_cnt[k][w]++;
      m_ptr[k] = (w + 1) % nm(k);
    end
    if (j >= 0 && !(hs && j == w)) begin
      if (m_cnt[k][j] == 0) m_err[k] = 1'b1;
      else m_cnt[k][j]--;
    end
  endtask

  // Compare process: outputs at negedge, model advances at posedge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      for (int k = 0; k < 2; k++) model_check(k);
      @(posedge clk);
      if (rst) model_reset();
      else for (int k = 0; k < 2; k++) model_update(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    add_i   = {$urandom, $urandom};
    wdata_i = {$urandom, $urandom};
    wen_i   = 4'($urandom);
    be_i    = 8'($urandom);
    aux_i   = $urandom;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req_i[k] = '0;
      gnt_i[k] = 1'b0;
      rv_i[k]  = 1'b0;
      rid_i[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rst.req_o_a", 64'(req_o[0]), 64'd0);
    chk("rst.stall_a", 64'(stall[0]), 64'd0);
    chk("rst.err_a", 64'(err_o[0]), 64'd0);
    chk("rst.gnt_b", 64'(gnt_o[1]), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    tick();
  endtask

  initial begin
    clear_inputs();
    add_i = '0; wdata_i = '0; wen_i = '0; be_i = '0; aux_i = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Rotation: A over 4 masters, B wrapping from 2 to 0
    req_i[0] = 4'b1111; req_i[1] = 4'b0111;
    gnt_i[0] = 1'b1;    gnt_i[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rot_a", 64'(id_o[0]), 64'(rot_a[c]));
      chk("rot_b", 64'(id_o[1]), 64'(rot_b[c]));
      chk("rot_err", 64'(err_o[0]), 64'd0);
      tick();
    end

    // Limit of 2 on master 1, released by a response
    do_reset();
    req_i[0] = 4'b0010; gnt_i[0] = 1'b1;
    @(negedge clk); chk("lim.g0", 64'(gnt_o[0]), 64'b0010); tick();
    @(negedge clk); chk("lim.g1", 64'(gnt_o[0]), 64'b0010); tick();
    @(negedge clk); chk("lim.stall", 64'(stall[0]), 64'b0010);
    chk("lim.req_o", 64'(req_o[0]), 64'd0); tick();
    cyc();
    rv_i[0] = 1'b1; rid_i[0] = 4'b0010;
    @(negedge clk); chk("lim.rvo", 64'(rvo[0]), 64'b0010);
    chk("lim.req_o4", 64'(req_o[0]), 64'd0); tick();
    rv_i[0] = 1'b0; rid_i[0] = '0;
    @(negedge clk); chk("lim.g5", 64'(gnt_o[0]), 64'b0010); tick();

    // Bridge grant held low: winner and pointer hold
    do_reset();
    req_i[0] = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold.id", 64'(id_o[0]), 64'b0001);
      chk("hold.gnt", 64'(gnt_o[0]), 64'd0);
      tick();
    end
    gnt_i[0] = 1'b1;
    @(negedge clk); chk("hold.g", 64'(gnt_o[0]), 64'b0001); tick();
    @(negedge clk); chk("hold.next", 64'(id_o[0]), 64'b0100); tick();

    // Grant and response to master 3 in the same cycle
    do_reset();
    req_i[0] = 4'b1000; gnt_i[0] = 1'b1;
    cyc();
    rv_i[0] = 1'b1; rid_i[0] = 4'b1000;
    @(negedge clk); chk("same.gnt", 64'(gnt_o[0]), 64'b1000);
    chk("same.rvo", 64'(rvo[0]), 64'b1000); tick();
    rv_i[0] = 1'b0; rid_i[0] = '0; req_i[0] = '0;
    @(negedge clk); chk("same.stall0", 64'(stall[0]), 64'd0); tick();
    req_i[0] = 4'b1000;
    @(negedge clk); chk("same.gnt2", 64'(gnt_o[0]), 64'b1000); tick();
    req_i[0] = '0;
    @(negedge clk); chk("same.stall1", 64'(stall[0]), 64'b1000); tick();

    // Response with nothing outstanding; sticky error
    do_reset();
    rv_i[0] = 1'b1; rid_i[0] = 4'b0100;
    cyc();
    rv_i[0] = 1'b0; rid_i[0] = '0;
    @(negedge clk); chk("err.set", 64'(err_o[0]), 64'd1); tick();
    @(negedge clk); chk("err.sticky", 64'(err_o[0]), 64'd1); tick();

    // Non-one-hot response ID: error, counters untouched
    do_reset();
    req_i[0] = 4'b0011; gnt_i[0] = 1'b1;
    cyc(); cyc();
    req_i[0] = '0; rv_i[0] = 1'b1; rid_i[0] = 4'b0011;
    @(negedge clk); chk("multi.rvo", 64'(rvo[0]), 64'b0011);
    chk("multi.err0", 64'(err_o[0]), 64'd0); tick();
    rv_i[0] = 1'b0; rid_i[0] = '0;
    @(negedge clk); chk("multi.err1", 64'(err_o[0]), 64'd1); tick();
    req_i[0] = 4'b0001;
    cyc();
    req_i[0] = '0;
    @(negedge clk); chk("multi.stall", 64'(stall[0]), 64'b0001); tick();

    // Late response after a reset discards the accounting
    do_reset();
    req_i[0] = 4'b0100; gnt_i[0] = 1'b1;
    cyc();
    do_reset();
    rv_i[0] = 1'b1; rid_i[0] = 4'b0100;
    cyc();
    rv_i[0] = 1'b0; rid_i[0] = '0;
    @(negedge clk); chk("late.err", 64'(err_o[0]), 64'd1); tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          int j;
          logic [3:0] mask;
          mask = (k == 0) ? 4'b1111 : 4'b0111;
          req_i[k] = 4'($urandom) & mask;
          gnt_i[k] = ($urandom_range(0, 9) < 7);
          rv_i[k]  = 1'b0;
          rid_i[k] = '0;
          j = int'($urandom_range(0, nm(k) - 1));
          if ($urandom_range(0, 1) == 1 && m_cnt[k][j] > 0) begin
            rv_i[k] = 1'b1;
            rid_i[k][j] = 1'b1;
          end
          if ($urandom_range(0, 199) == 0) begin
            rv_i[k] = 1'b1;
            rid_i[k] = 4'($urandom) & mask;
          end
        end
        cyc();
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
